// File: rtl/rgb_pwm_driver.sv
// rtl/rgb_pwm_driver.sv - double-buffered RGB PWM driver, optional RGB_BRIGHTNESS_EN scaling
// Pending colour moves to active only at PWM wrap, so pins never glitch mid-period.
module rgb_pwm_driver #(
   parameter int          PRESCALE     = 4,
   parameter logic [23:0] RESET_COLOUR = 24'h000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] colour_in,
   input  logic        colour_valid,
   output logic        colour_ready,
   input  logic        enable,
   output logic        led_r,
   output logic        led_g,
   output logic        led_b,
   output logic        period_tick
`ifdef RGB_BRIGHTNESS_EN
   ,
   input  logic [7:0]  brightness
`endif
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [23:0]   pending_q, pending_d;
   logic          full_q, full_d;
   logic [23:0]   active_q, active_d;
   logic [2:0]    led_q, led_d;
   logic          tick_q, tick_d;
   logic [23:0]   duty;
   logic          step, wrap, accept;

   assign colour_ready = ~full_q & ~rst;
   assign accept       = colour_valid & colour_ready;
   assign step         = enable && (presc_q == PRESC_MAX);
   assign wrap         = step && (cnt_q == 8'hFF);

   always_comb begin
      presc_d   = (!enable || step) ? '0 : presc_q + PW'(1);
      cnt_d     = !enable ? 8'd0 : (step ? cnt_q + 8'd1 : cnt_q);
      active_d  = active_q;
      pending_d = pending_q;
      full_d    = full_q;
      // Accept and reload never coincide: a reload needs a full buffer, which blocks ready.
      if (wrap && full_q) begin
         active_d = pending_q;
         full_d   = 1'b0;
      end
      if (accept) begin
         pending_d = colour_in;
         full_d    = 1'b1;
      end
      tick_d = wrap;
      led_d  = {enable && (cnt_q < duty[23:16]),
                enable && (cnt_q < duty[15:8]),
                enable && (cnt_q < duty[7:0])};
   end

`ifdef RGB_BRIGHTNESS_EN
   logic [23:0] duty_q, duty_d;

   function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
      logic [15:0] prod;
      prod  = {8'd0, c} * ({8'd0, b} + 16'd1);
      scale = 8'(prod >> 8);
   endfunction

   // Brightness is sampled only at wrap so a change can never split a period.
   always_comb begin
      duty_d = duty_q;
      if (wrap) duty_d = {scale(active_d[23:16], brightness),
                          scale(active_d[15:8],  brightness),
                          scale(active_d[7:0],   brightness)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) duty_q <= RESET_COLOUR;
      else     duty_q <= duty_d;
   end

   assign duty = duty_q;
`else
   assign duty = active_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q   <= '0;
         cnt_q     <= 8'd0;
         pending_q <= 24'd0;
         full_q    <= 1'b0;
         active_q  <= RESET_COLOUR;
         led_q     <= 3'b000;
         tick_q    <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         full_q    <= full_d;
         active_q  <= active_d;
         led_q     <= led_d;
         tick_q    <= tick_d;
      end
   end

   assign led_r       = led_q[2];
   assign led_g       = led_q[1];
   assign led_b       = led_q[0];
   assign period_tick = tick_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb/tb_rgb_pwm_driver.sv - scoreboard bench for rgb_pwm_driver (PRESCALE=1 and PRESCALE=4 instances)
module tb_rgb_pwm_driver;

   typedef struct {int r; int g; int b;} exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] colour_in = 24'd0;
   logic        colour_valid = 1'b0;
   logic        colour_ready;
   logic        enable = 1'b1;
   logic        led_r, led_g, led_b, period_tick;
   logic [23:0] colour4 = 24'd0;
   logic        valid4 = 1'b0;
   logic        ready4, led_r4, led_g4, led_b4, tick4;
`ifdef RGB_BRIGHTNESS_EN
   logic [7:0]  brightness = 8'hFF;
`endif

   int   tests = 0;
   int   failed = 0;
   exp_t sb_q[$];
   exp_t armed_exp;
   bit   armed = 0;
   bit   win = 0;
   int   cr = 0, cg = 0, cb = 0;

   always #5 clk = ~clk;

   rgb_pwm_driver #(.PRESCALE(1), .RESET_COLOUR(24'h000000)) u_dut (
      .clk(clk), .rst(rst), .colour_in(colour_in), .colour_valid(colour_valid),
      .colour_ready(colour_ready), .enable(enable), .led_r(led_r), .led_g(led_g),
      .led_b(led_b), .period_tick(period_tick)
`ifdef RGB_BRIGHTNESS_EN
      , .brightness(brightness)
`endif
   );

   rgb_pwm_driver #(.PRESCALE(4), .RESET_COLOUR(24'h000000)) u_dut4 (
      .clk(clk), .rst(rst), .colour_in(colour4), .colour_valid(valid4),
      .colour_ready(ready4), .enable(1'b1), .led_r(led_r4), .led_g(led_g4),
      .led_b(led_b4), .period_tick(tick4)
`ifdef RGB_BRIGHTNESS_EN
      , .brightness(8'hFF)
`endif
   );

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Monitor: each period_tick closes the previous 256-sample window and arms the next expectation.
   always @(negedge clk) begin
      if (rst) begin
         win = 0; armed = 0;
      end else begin
         if (win) begin
            cr += int'(led_r); cg += int'(led_g); cb += int'(led_b);
         end
         if (period_tick) begin
            if (armed && win) begin
               check("period_led_r_high", cr, armed_exp.r);
               check("period_led_g_high", cg, armed_exp.g);
               check("period_led_b_high", cb, armed_exp.b);
            end
            armed = 0;
            if (sb_q.size() > 0) begin
               armed_exp = sb_q.pop_front();
               armed = 1;
            end
            cr = 0; cg = 0; cb = 0; win = 1;
         end
      end
   end

   task automatic wait_tick(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_tick && n < 3000);
      if (!period_tick) check(name, 0, 1);
   endtask

   task automatic send(input logic [23:0] c, input int er, input int eg, input int eb,
                       output int waited, output logic tk);
      exp_t e;
      @(negedge clk);
      colour_in = c;
      colour_valid = 1'b1;
      waited = 0;
      while (!colour_ready && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      tk = period_tick;
      if (!colour_ready) check("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      colour_valid = 1'b0;
      e.r = er; e.g = eg; e.b = eb;
      sb_q.push_back(e);
   endtask

   initial begin
      #200000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int   w, n, cnt4;
      logic tk;
      int   ticks, leds_on;

      // Reset state
      #23;
      check("reset_leds", int'({led_r, led_g, led_b}), 0);
      check("reset_ready_low", int'(colour_ready), 0);
      check("reset_tick", int'(period_tick), 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("ready_after_release", int'(colour_ready), 1);

      // FF0080: 255 / 0 / 128 high counts per period
      wait_tick("t2_tick");
      send(24'hFF0080, 255, 0, 128, w, tk);
      check("t2_ready_low_after_accept", int'(colour_ready), 0);
      wait_tick("t2_load");
      wait_tick("t2_cmp");

      // Two words in one period: second stalls until the cycle after wrap
      send(24'h100000, 16, 0, 0, w, tk);
      send(24'h200000, 32, 0, 0, w, tk);
      check("t3_second_stalled", int'(w > 0), 1);
      check("t3_ready_rises_on_tick_cycle", int'(tk), 1);
      wait_tick("t3_a");
      wait_tick("t3_b");

      // Asynchronous reset mid-period with led_r high
      wait_tick("t1_tick");
      repeat (5) @(negedge clk);
      check("t1_led_r_high_before_reset", int'(led_r), 1);
      #2 rst = 1'b1;
      #1;
      check("t1_leds_cleared_async", int'({led_r, led_g, led_b}), 0);
      check("t1_ready_low_in_reset", int'(colour_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("t1_ready_one_cycle_after", int'(colour_ready), 1);

      // 808080 verified for a full period, then disable mid-period
      wait_tick("t4_tick");
      send(24'h808080, 128, 128, 128, w, tk);
      wait_tick("t4_load");
      wait_tick("t4_cmp");
      repeat (10) @(negedge clk);
      check("t4_leds_on_before_disable", int'({led_r, led_g, led_b}), 7);
      enable = 1'b0;
      @(posedge clk); #1;
      check("t4_leds_off_next_cycle", int'({led_r, led_g, led_b}), 0);
      ticks = 0; leds_on = 0;
      repeat (300) begin
         @(negedge clk);
         ticks += int'(period_tick);
         leds_on += int'(led_r | led_g | led_b);
      end
      check("t4_no_tick_disabled", ticks, 0);
      check("t4_leds_dark_disabled", leds_on, 0);
      enable = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_tick && n < 3000);
      check("t4_first_tick_after_enable", n, 256);

      // PRESCALE=4 instance: tick spacing and one-count duty
      @(negedge clk);
      colour4 = 24'h010000;
      valid4 = 1'b1;
      n = 0;
      while (!ready4 && n < 5000) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      valid4 = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!tick4 && n < 5000);
      check("t6_load_tick_seen", int'(tick4), 1);
      n = 0; cnt4 = 0;
      do begin
         @(negedge clk);
         n++;
         cnt4 += int'(led_r4);
      end while (!tick4 && n < 5000);
      check("t6_tick_spacing", n, 1024);
      check("t6_led_r_high_clks", cnt4, 4);
      check("t6_led_g_low", int'(led_g4), 0);

`ifdef RGB_BRIGHTNESS_EN
      // Brightness 0x80 on full white: duty 128 per channel
      wait_tick("t5_tick");
      brightness = 8'h80;
      send(24'hFFFFFF, 128, 128, 128, w, tk);
      wait_tick("t5_load");
      wait_tick("t5_cmp");
`endif

      repeat (3) @(negedge clk);
      check("sb_queue_drained", sb_q.size(), 0);
      check("sb_nothing_armed", int'(armed), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
